// File: rtl/countdown_hat_pkg.sv
// hat_timer_pkg: count range and state type shared by the hat up/down counters
//   WIDTH     count width in bits
//   MAXCOUNT  largest loadable count; larger load values saturate to it
package hat_timer_pkg;
  localparam int WIDTH = 14;
  localparam logic [WIDTH-1:0] MAXCOUNT = 14'd12348;
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] x);
    return (x > MAXCOUNT) ? MAXCOUNT : x;
  endfunction
endpackage

// File: rtl/countdown_hat_if.sv
// countdown_hat_if: control and status bundle of the countdown timer
//   master drives load/load_val/en; slave returns count/busy/done/expired
interface countdown_hat_if;
  logic load;
  logic [hat_timer_pkg::WIDTH-1:0] load_val;
  logic en;
  logic [hat_timer_pkg::WIDTH-1:0] count;
  logic busy;
  logic done;
  logic expired;
  modport master(output load, load_val, en, input count, busy, done, expired);
  modport slave(input load, load_val, en, output count, busy, done, expired);
endinterface

// File: rtl/countdown_hat.sv
// countdown_hat: loadable down-counter raising done/expired when it reaches zero
//   clk    single clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    slave side of countdown_hat_if (load, load_val, en -> count, busy, done, expired)
//   COUNTDOWN_AUTO_RELOAD_EN: when defined, expiry reloads the last loaded value and keeps running
module countdown_hat
  import hat_timer_pkg::*;
(
  input logic clk,
  input logic reset,
  countdown_hat_if.slave bus
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, v;
  logic busy_q, busy_d, done_q, done_d, expired_q, expired_d;
  assign v = sat(bus.load_val);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  always_ff @(posedge clk)
    reload_q <= reset ? '0 : bus.load ? v : reload_q;
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d = busy_q;
    done_d = 1'b0;
    expired_d = expired_q;
    if (bus.load) begin
      count_d = v;
      state_d = (v != '0) ? RUN : EXPIRED;
      busy_d = (v != '0);
      expired_d = (v == '0);
    end else if (state_q == RUN && bus.en) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
        state_d = EXPIRED;
        busy_d = 1'b0;
        expired_d = 1'b1;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q <= busy_d;
      done_q <= done_d;
      expired_q <= expired_d;
    end
  end
  assign bus.count = count_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.expired = expired_q;
endmodule

// File: tb/tb_countdown_hat.sv
// tb_countdown_hat: directed vector table plus randomized run against a behavioural timer model
module tb_countdown_hat;
  logic clk = 1'b0;
  logic reset;
  countdown_hat_if bus();
  countdown_hat dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    bit r;
    bit l;
    int lv;
    bit e;
    int c;
    bit b;
    bit d;
    bit x;
  } vec_t;
  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;
  int m_mode = 0;
  int m_cnt = 0;
  int m_rel = 0;
  bit m_done = 1'b0;
  function automatic vec_t mk(bit r, bit l, int lv, bit e, int c, bit b, bit d, bit x);
    vec_t t;
    t.r = r; t.l = l; t.lv = lv; t.e = e; t.c = c; t.b = b; t.d = d; t.x = x;
    return t;
  endfunction
  task automatic chk(input string name, input int step, input int c, input bit b, input bit d, input bit x);
    logic [16:0] want;
    want = {14'(c), b, d, x};
    n_vec++;
    if ({bus.count, bus.busy, bus.done, bus.expired} !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got count=%0d busy=%b done=%b expired=%b, want count=%0d busy=%b done=%b expired=%b",
               name, step, bus.count, bus.busy, bus.done, bus.expired, c, b, d, x);
    end
  endtask
  // Model: mode 0 idle, 1 running, 2 expired; busy/expired follow directly from mode.
  task automatic cyc(input bit r, input bit l, input int lv, input bit e);
    int v;
    reset = r;
    bus.load = l;
    bus.load_val = 14'(lv);
    bus.en = e;
    @(posedge clk);
    v = (lv > 12348) ? 12348 : lv;
    m_done = 1'b0;
    if (r) begin
      m_mode = 0;
      m_cnt = 0;
    end else if (l) begin
      m_rel = v;
      m_cnt = v;
      m_mode = (v != 0) ? 1 : 2;
    end else if (m_mode == 1 && e) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin
        m_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_cnt = m_rel;
`else
        m_cnt = 0;
        m_mode = 2;
`endif
      end
    end
    #1;
  endtask
  initial begin
    reset = 1'b1;
    bus.load = 1'b0;
    bus.load_val = '0;
    bus.en = 1'b0;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 1, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 5, 0, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16000, 1, 12348, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 12347, 1, 0, 0));
    tbl.push_back(mk(0, 1, 12348, 0, 12348, 1, 0, 0));
    tbl.push_back(mk(0, 1, 12349, 0, 12348, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 2, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 7, 1, 7, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 6, 1, 0, 0));
    tbl.push_back(mk(0, 1, 100, 0, 100, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 9, 1, 0, 0, 0, 0));
`else
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
`endif
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].l, tbl[i].lv, tbl[i].e);
      chk("table", i, tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].x);
      chk("table_model", i, m_cnt, m_mode == 1, m_done, m_mode == 2);
    end
    for (int i = 0; i < 600; i++) begin
      int lv;
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 6));
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, lv, $urandom_range(0, 1) == 1);
      chk("random", i, m_cnt, m_mode == 1, m_done, m_mode == 2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
